// File: rtl/mmul_pkg.sv
// Shared types and helpers for the 3-operand matrix multiplier slice.
package mmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to hold a sum of ca products of two w-bit operands,
    // plus one bit so signed and unsigned results share the same width.
    function automatic int mmul_out_width(input int w, input int ca);
        return 2 * w + $clog2(ca) + 1;
    endfunction

endpackage

// File: rtl/mmul_mac.sv
// Multiply-accumulate unit: W x W product (signed or unsigned), extended to OW
// bits and added into an OW-bit wrapping accumulator.
module mmul_mac #(
    parameter int W  = 8,
    parameter int OW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clear,
    input  logic          signed_mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] sum
);

    logic signed [W:0]     a_ext;
    logic signed [W:0]     b_ext;
    logic signed [2*W+1:0] prod;
    logic [OW-1:0]         prod_ext;
    logic [OW-1:0]         acc_d;
    logic [OW-1:0]         acc_q;

    // Extend operands by one bit so a single signed multiplier covers both modes;
    // sum is the value the accumulator takes on this cycle.
    always_comb begin
        a_ext    = $signed({signed_mode & a[W-1], a});
        b_ext    = $signed({signed_mode & b[W-1], b});
        prod     = a_ext * b_ext;
        prod_ext = OW'(prod);
        sum      = clear ? prod_ext : acc_q + prod_ext;
        acc_d    = en ? sum : acc_q;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mmul3.sv
// Sequential matrix multiplier C = A x B using a single MAC unit.
// Elements are computed k innermost, then j, then i; one MAC per enabled cycle.
module mmul3
    import mmul_pkg::*;
#(
    parameter int RA = 3,
    parameter int CA = 2,
    parameter int CB = 4,
    parameter int W  = 8,
    parameter int OW = mmul_out_width(W, CA)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  signed_mode,
    input  logic [RA*CA*W-1:0]    A,
    input  logic [CA*CB*W-1:0]    B,
    output logic [RA*CB*OW-1:0]   C,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int IW = (RA > 1) ? $clog2(RA) : 1;
    localparam int JW = (CB > 1) ? $clog2(CB) : 1;
    localparam int KW = (CA > 1) ? $clog2(CA) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(RA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(CB - 1);
    localparam logic [KW-1:0] K_LAST = KW'(CA - 1);

    if (OW < 2 * W) begin : g_ow_check
        $error("mmul3: OW must be at least 2*W");
    end

    state_t               state_d, state_q;
    logic [IW-1:0]        i_d, i_q;
    logic [JW-1:0]        j_d, j_q;
    logic [KW-1:0]        k_d, k_q;
    logic                 fin_d, fin_q;
    logic                 sm_d, sm_q;
    logic [RA*CA*W-1:0]   a_d, a_q;
    logic [CA*CB*W-1:0]   b_d, b_q;
    logic [RA*CB*OW-1:0]  c_d, c_q;
    logic                 mac_en;
    logic                 mac_clear;
    logic [W-1:0]         a_sel;
    logic [W-1:0]         b_sel;
    logic [OW-1:0]        mac_sum;
    int                   a_idx;
    int                   b_idx;
    int                   c_idx;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign C         = c_q;

    mmul_mac #(.W(W), .OW(OW)) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (mac_en),
        .clear       (mac_clear),
        .signed_mode (sm_q),
        .a           (a_sel),
        .b           (b_sel),
        .sum         (mac_sum)
    );

    // Next-state, counter sequencing and result write-back.
    // fin_q marks that the final MAC has landed; DONE follows one cycle later,
    // giving a latency of RA*CB*CA+1 edges from accept to out_valid.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        fin_d     = fin_q;
        sm_d      = sm_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        mac_en    = 1'b0;
        mac_clear = 1'b0;
        a_idx     = RA * CA - 1 - (int'(i_q) * CA + int'(k_q));
        b_idx     = CA * CB - 1 - (int'(k_q) * CB + int'(j_q));
        c_idx     = RA * CB - 1 - (int'(i_q) * CB + int'(j_q));
        a_sel     = a_q[a_idx*W +: W];
        b_sel     = b_q[b_idx*W +: W];
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = A;
                        b_d     = B;
                        sm_d    = signed_mode;
                        c_d     = '0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        fin_d   = 1'b0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    if (fin_q) begin
                        fin_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        mac_en    = 1'b1;
                        mac_clear = (k_q == '0);
                        if (k_q == K_LAST) begin
                            c_d[c_idx*OW +: OW] = mac_sum;
                            k_d = '0;
                            if (j_q == J_LAST) begin
                                j_d = '0;
                                if (i_q == I_LAST) begin
                                    i_d   = '0;
                                    fin_d = 1'b1;
                                end else begin
                                    i_d = i_q + 1'b1;
                                end
                            end else begin
                                j_d = j_q + 1'b1;
                            end
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters, captured operands and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            fin_q   <= 1'b0;
            sm_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            fin_q   <= fin_d;
            sm_q    <= sm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_mmul3.sv
// Self-checking bench for mmul3 with default parameters (3x2 * 2x4, W=8, OW=18).
module tb_mmul3;

    localparam int RA = 3, CA = 2, CB = 4, W = 8, OW = 18;
    localparam int AW = RA * CA * W;
    localparam int BW = CA * CB * W;
    localparam int CWD = RA * CB * OW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            signed_mode = 1'b0;
    logic [AW-1:0]   A = '0;
    logic [BW-1:0]   B = '0;
    logic [CWD-1:0]  C;
    logic            out_valid;
    logic            out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmul3 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .C           (C),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // Reference: textbook matrix product on integers, reduced modulo 2^OW.
    function automatic logic [CWD-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                             input logic sm);
        logic [CWD-1:0] c;
        logic [W-1:0]   av, bv;
        longint         s, ea, eb;
        c = '0;
        for (int i = 0; i < RA; i++) begin
            for (int j = 0; j < CB; j++) begin
                s = 0;
                for (int k = 0; k < CA; k++) begin
                    av = a[(RA*CA-1-(i*CA+k))*W +: W];
                    bv = b[(CA*CB-1-(k*CB+j))*W +: W];
                    ea = sm ? longint'($signed(av)) : longint'(av);
                    eb = sm ? longint'($signed(bv)) : longint'(bv);
                    s  = s + ea * eb;
                end
                c[(RA*CB-1-(i*CB+j))*OW +: OW] = s[OW-1:0];
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [CWD-1:0] obs, input logic [CWD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair; called #1 after an edge while the DUT is IDLE.
    // Inputs are scrambled after the accepting edge to show they were captured.
    task automatic start_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sm);
        A = a; B = b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = AW'({$urandom(), $urandom()});
        B = BW'({$urandom(), $urandom()});
        signed_mode = ~sm;
    endtask

    // Wait (bounded) for out_valid, checking latency, a partial-result snapshot and C.
    task automatic wait_result(input string tag, input logic [CWD-1:0] exp, input int exp_lat,
                               input int stall_at);
        int edges;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 300) begin
            if (stall_at >= 0 && edges == stall_at) enable = 1'b0;
            @(posedge clk); #1;
            edges++;
            if (stall_at >= 0 && edges == stall_at + 5) enable = 1'b1;
            if (edges == 3) begin
                chk({tag, "_busy_ready"}, CWD'(in_ready), CWD'(0));
                chk({tag, "_partial"}, CWD'(C[CWD-OW-1:0]), CWD'(0));
            end
        end
        enable = 1'b1;
        chk({tag, "_latency"}, CWD'(edges), CWD'(exp_lat));
        chk({tag, "_C"}, C, exp);
    endtask

    // Complete the output handshake and confirm return to IDLE.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, CWD'(out_valid), CWD'(0));
        chk({tag, "_post_ready"}, CWD'(in_ready), CWD'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0]  ra;
        logic [BW-1:0]  rb;
        logic           rs;
        logic [CWD-1:0] e1, e2;

        // Reset state, observed asynchronously before any clock activity matters.
        #3;
        chk("rst_in_ready", CWD'(in_ready), CWD'(1));
        chk("rst_out_valid", CWD'(out_valid), CWD'(0));
        chk("rst_C", C, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed unsigned example with hand-computed result.
        e1 = {18'd11, 18'd14, 18'd17, 18'd20, 18'd23, 18'd30,
              18'd37, 18'd44, 18'd35, 18'd46, 18'd57, 18'd68};
        start_op(48'h010203040506, 64'h0102030405060708, 1'b0);
        wait_result("dir_u", e1, 25, -1);
        chk("dir_u_model", model(48'h010203040506, 64'h0102030405060708, 1'b0), e1);

        // Output hold with out_ready low; in_valid pulses must be ignored.
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0];
            @(posedge clk); #1;
            chk("hold_C", C, e1);
            chk("hold_valid", CWD'(out_valid), CWD'(1));
            chk("hold_in_ready", CWD'(in_ready), CWD'(0));
        end
        in_valid = 1'b0;

        // enable low in DONE blocks the handshake.
        enable = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("en_low_done_valid", CWD'(out_valid), CWD'(1));
        enable = 1'b1; out_ready = 1'b0;
        finish_op("dir_u");

        // All -1 times 2, signed and unsigned interpretations.
        e1 = '0;
        for (int n = 0; n < RA * CB; n++) e1[n*OW +: OW] = 18'h3FFFC;
        start_op({6{8'hFF}}, {8{8'h02}}, 1'b1);
        wait_result("neg_s", e1, 25, -1);
        finish_op("neg_s");
        e1 = '0;
        for (int n = 0; n < RA * CB; n++) e1[n*OW +: OW] = 18'd1020;
        start_op({6{8'hFF}}, {8{8'h02}}, 1'b0);
        wait_result("neg_u", e1, 25, -1);
        finish_op("neg_u");

        // Random operations, one with a 5-cycle enable stall mid-computation.
        for (int t = 0; t < 5; t++) begin
            ra = AW'({$urandom(), $urandom()});
            rb = BW'({$urandom(), $urandom()});
            rs = 1'($urandom_range(0, 1));
            start_op(ra, rb, rs);
            if (t == 2) wait_result("rnd_stall", model(ra, rb, rs), 30, 7);
            else        wait_result("rnd", model(ra, rb, rs), 25, -1);
            finish_op("rnd");
        end

        // Reset asserted during CALC after 10 MACs.
        ra = AW'({$urandom(), $urandom()});
        rb = BW'({$urandom(), $urandom()});
        start_op(ra, rb, 1'b1);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", CWD'(out_valid), CWD'(0));
        chk("mid_rst_C", C, '0);
        chk("mid_rst_ready", CWD'(in_ready), CWD'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("after_rst_valid", CWD'(out_valid), CWD'(0));
        start_op(ra, rb, 1'b0);
        wait_result("after_rst", model(ra, rb, 1'b0), 25, -1);
        finish_op("after_rst");

        // Back-to-back with out_ready held high: one IDLE cycle between operations.
        ra = AW'({$urandom(), $urandom()});
        rb = BW'({$urandom(), $urandom()});
        e1 = model(ra, rb, 1'b0);
        out_ready = 1'b1;
        start_op(ra, rb, 1'b0);
        wait_result("b2b_1", e1, 25, -1);
        ra = AW'({$urandom(), $urandom()});
        rb = BW'({$urandom(), $urandom()});
        e2 = model(ra, rb, 1'b1);
        A = ra; B = rb; signed_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_idle_valid", CWD'(out_valid), CWD'(0));
        chk("b2b_idle_ready", CWD'(in_ready), CWD'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = '0; B = '0; signed_mode = 1'b0;
        chk("b2b_accept_ready", CWD'(in_ready), CWD'(0));
        wait_result("b2b_2", e2, 25, -1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_end_ready", CWD'(in_ready), CWD'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
